vx_sau_req_arb: RTL

- Parametrised N-to-1 request concentrator in front of the SAU execute unit.
- Takes NUM_REQS independent valid/ready request channels, each carrying a packed SAU request payload (uuid/wid/tmask/PC/op/rs data/rd/wb flattened to DATAW bits).
- Arbitrates round-robin and buffers winners in a BUF_DEPTH elastic FIFO, so the SAU slave sees one registered valid/ready stream tagged with its source channel.
- Successor to the single-channel, payload-less SAU request handshake.

---
 rtl/vx_sau_req_arb_pkg.sv | 26 ++
 rtl/vx_sau_req_arb_if.sv | 28 ++
 rtl/vx_sau_req_arb_rr_arbiter.sv | 41 ++++
 rtl/vx_sau_req_arb.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vx_sau_req_arb_pkg.sv
// Shared SAU request definitions: payload layout, derived payload width and the
// channel-index width helper used by the request concentrator and its interface.
// No ports; pure types/constants.
package VX_sau_pkg;

   // Flattened SAU request payload; field order fixes the bit layout of DATAW.
   typedef struct packed {
      logic [13:0] uuid;
      logic [3:0]  wid;
      logic [3:0]  tmask;
      logic [31:0] pc;
      logic [3:0]  op;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rd;
      logic        wb;
   } sau_req_t;

   localparam int SAU_REQ_DATAW = $bits(sau_req_t);

   // Width of a channel index; a single channel still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_sau_req_arb_if.sv
// Bundle of the N request channels and the single buffered SAU stream.
// master: requesters + SAU side (drives req_valid/req_data/rsp_ready).
// slave : the concentrator (drives req_ready/rsp_valid/rsp_data/rsp_index).
interface vx_sau_req_arb_if
   import VX_sau_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = SAU_REQ_DATAW,
   parameter int IDXW     = idx_w(NUM_REQS)
);
   logic [NUM_REQS-1:0]       req_valid;
   logic [NUM_REQS*DATAW-1:0] req_data;
   logic [NUM_REQS-1:0]       req_ready;
   logic                      rsp_valid;
   logic [DATAW-1:0]          rsp_data;
   logic [IDXW-1:0]           rsp_index;
   logic                      rsp_ready;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_index
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_index
   );
endinterface

// File: rtl/vx_sau_req_arb_rr_arbiter.sv
// Round-robin pick: first asserted request at or after rr_ptr, wrapping modulo NUM_REQS.
// Purely combinational (zero latency); no backpressure of its own.
// Ports: requests_i (per-channel valid), rr_ptr_i (search start), grant_o (one-hot or zero), grant_index_o.
module vx_rr_arbiter
   import VX_sau_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int IDXW     = idx_w(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] requests_i,
   input  logic [IDXW-1:0]     rr_ptr_i,
   output logic [NUM_REQS-1:0] grant_o,
   output logic [IDXW-1:0]     grant_index_o
);

   if (NUM_REQS == 1) begin : g_single
      // Nothing to arbitrate: the lone request is its own grant.
      logic unused_rr;
      assign unused_rr     = ^rr_ptr_i;
      assign grant_o       = requests_i;
      assign grant_index_o = '0;
   end else begin : g_multi
      always_comb begin
         int  idx;
         logic found;
         idx           = 0;
         found         = 1'b0;
         grant_o       = '0;
         grant_index_o = '0;
         for (int off = 0; off < NUM_REQS; off++) begin
            idx = (int'(rr_ptr_i) + off) % NUM_REQS;
            if (!found && requests_i[idx]) begin
               found          = 1'b1;
               grant_o[idx]   = 1'b1;
               grant_index_o  = IDXW'(idx);
            end
         end
      end
   end

endmodule

// File: rtl/vx_sau_req_arb.sv
// N-to-1 SAU request concentrator: round-robin arbitration into a BUF_DEPTH FIFO.
// Latency: accepted request visible on rsp_valid one cycle later at the earliest.
// Backpressure: req_ready only for the granted channel and only when the FIFO is not full;
// ready never depends on rsp_ready. Optional perf counters behind VX_SAU_PERF_EN.
// Ports: clk, reset (async active-low), bus (slave modport: request channels + SAU stream),
// perf_stalls/perf_grants (only with VX_SAU_PERF_EN).
module vx_sau_req_arb
   import VX_sau_pkg::*;
#(
   parameter int NUM_REQS  = 4,
   parameter int DATAW     = SAU_REQ_DATAW,
   parameter int BUF_DEPTH = 4,
   parameter int PERF_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   vx_sau_req_arb_if.slave   bus
`ifdef VX_SAU_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stalls,
   output logic [PERF_W-1:0] perf_grants
`endif
);

   localparam int IDXW = idx_w(NUM_REQS);
   localparam int PTRW = $clog2(BUF_DEPTH);
   localparam int CNTW = PTRW + 1;

   typedef struct packed {
      logic [IDXW-1:0]  idx;
      logic [DATAW-1:0] data;
   } entry_t;

   entry_t              mem_q [BUF_DEPTH];
   logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CNTW-1:0]     count_q, count_d;
   logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;

   logic [NUM_REQS-1:0] grant;
   logic [IDXW-1:0]     grant_index;
   logic [NUM_REQS-1:0] req_ready_w;
   logic [DATAW-1:0]    win_data;
   logic                full, push, pop, rsp_valid_w;

   vx_rr_arbiter #(
      .NUM_REQS (NUM_REQS),
      .IDXW     (IDXW)
   ) u_arb (
      .requests_i    (bus.req_valid),
      .rr_ptr_i      (rr_ptr_q),
      .grant_o       (grant),
      .grant_index_o (grant_index)
   );

   assign full        = (count_q == CNTW'(BUF_DEPTH));
   // Gating with reset keeps ready low while held in reset even though the
   // arbiter itself is combinational on req_valid.
   assign req_ready_w = grant & {NUM_REQS{~full & reset}};
   assign push        = |req_ready_w;
   assign rsp_valid_w = (count_q != '0);
   assign pop         = rsp_valid_w & bus.rsp_ready;
   assign win_data    = bus.req_data[int'(grant_index)*DATAW +: DATAW];

   assign bus.req_ready = req_ready_w;
   assign bus.rsp_valid = rsp_valid_w;
   assign bus.rsp_data  = mem_q[rd_ptr_q].data;
   assign bus.rsp_index = mem_q[rd_ptr_q].idx;

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rr_ptr_d = rr_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTRW'(1);
         // Next search starts just past the winner, wrapping at NUM_REQS.
         rr_ptr_d = (grant_index == IDXW'(NUM_REQS - 1)) ? '0 : grant_index + IDXW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Storage is cleared so the head reads as zero straight out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= {grant_index, win_data};
      end
   end

`ifdef VX_SAU_PERF_EN
   logic [PERF_W-1:0] perf_stalls_q, perf_grants_q;
   logic              stall;

   assign stall = (|bus.req_valid) & ~push;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stalls_q <= '0;
         perf_grants_q <= '0;
      end else begin
         if (push && !(&perf_grants_q)) begin
            perf_grants_q <= perf_grants_q + PERF_W'(1);
         end
         if (stall && !(&perf_stalls_q)) begin
            perf_stalls_q <= perf_stalls_q + PERF_W'(1);
         end
      end
   end

   assign perf_stalls = perf_stalls_q;
   assign perf_grants = perf_grants_q;
`else
   localparam int unused_perf_w = PERF_W;
`endif

endmodule
